// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - RV32I stall/flush sequencer (load-use, taken branch, dmem wait)
// Optional PIPE_PERF_CNT_EN adds stall and flush event counters.
module pipeline_stall_controller #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        ip_clk,
    input  logic        ip_rst,
    input  logic        ip_Load_Use,
    input  logic        ip_Branch_Taken,
    input  logic        ip_DMem_Req,
    input  logic        ip_DMem_Ready,
    output logic        op_PCWrite,
    output logic        op_IF_ID_Write,
    output logic        op_IF_ID_Flush,
    output logic        op_ID_EX_Flush,
    output logic        op_Pipe_Freeze,
    output logic        op_Mem_Timeout,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] op_Stall_Cnt,
    output logic [31:0] op_Flush_Cnt,
`endif
    output logic [1:0]  op_State
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        BR_FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] BR_INIT     = 2'(BR_PENALTY - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     state, stateNext;
    logic [1:0] brCnt, brCntNext;
    logic [7:0] toCnt, toCntNext;
    logic       timeoutFlag, timeoutNext;
    logic       luMask, luMaskNext;
    logic       branchAccept;
    logic       freezeReq, runEval, luEnable, brResume;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze;
    logic       dmemStall;

    assign dmemStall = ip_DMem_Req & ~ip_DMem_Ready;

    always_comb begin
        stateNext    = state;
        brCntNext    = brCnt;
        toCntNext    = toCnt;
        timeoutNext  = timeoutFlag;
        luMaskNext   = luMask;
        branchAccept = 1'b0;
        freezeReq    = 1'b0;
        runEval      = 1'b0;
        luEnable     = 1'b0;
        brResume     = 1'b0;
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        ifIdFlush    = 1'b0;
        idExFlush    = 1'b0;
        pipeFreeze   = 1'b0;

        case (state)
            RUN, LU_STALL: begin
                if (dmemStall) begin
                    freezeReq  = 1'b1;
                    toCntNext  = 8'd1;
                    luMaskNext = (state == LU_STALL);
                    stateNext  = MEM_WAIT;
                end else begin
                    runEval  = 1'b1;
                    luEnable = (state == RUN);
                end
            end
            MEM_WAIT: begin
                if (!ip_DMem_Ready) begin
                    freezeReq = 1'b1;
                    toCntNext = (toCnt == 8'hFF) ? toCnt : toCnt + 8'd1;
                end else begin
                    toCntNext  = 8'd0;
                    luMaskNext = 1'b0;
                    // An interrupted branch flush resumes before normal issue restarts
                    if (brCnt != 2'd0) brResume = 1'b1;
                    else begin
                        runEval  = 1'b1;
                        luEnable = ~luMask;
                    end
                end
            end
            BR_FLUSH: begin
                if (dmemStall) begin
                    freezeReq  = 1'b1;
                    toCntNext  = 8'd1;
                    luMaskNext = 1'b0;
                    stateNext  = MEM_WAIT;
                end else begin
                    brResume = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase

        if (brResume) begin
            ifIdFlush = 1'b1;
            brCntNext = brCnt - 2'd1;
            stateNext = (brCnt == 2'd1) ? RUN : BR_FLUSH;
        end

        if (runEval) begin
            stateNext = RUN;
            if (ip_Branch_Taken) begin
                ifIdFlush    = 1'b1;
                idExFlush    = 1'b1;
                branchAccept = 1'b1;
                if (BR_PENALTY > 1) begin
                    stateNext = BR_FLUSH;
                    brCntNext = BR_INIT;
                end
            end else if (luEnable && ip_Load_Use) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
                stateNext = LU_STALL;
            end
        end

        if (freezeReq) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            pipeFreeze = 1'b1;
            if (toCntNext == TIMEOUT_VAL) timeoutNext = 1'b1;
        end
    end

    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            state       <= RUN;
            brCnt       <= 2'd0;
            toCnt       <= 8'd0;
            timeoutFlag <= 1'b0;
            luMask      <= 1'b0;
        end else begin
            state       <= stateNext;
            brCnt       <= brCntNext;
            toCnt       <= toCntNext;
            timeoutFlag <= timeoutNext;
            luMask      <= luMaskNext;
        end
    end

    // Reset holds the front end and flushes IF/ID and ID/EX until released
    assign op_PCWrite     = ip_rst ? 1'b0 : pcWrite;
    assign op_IF_ID_Write = ip_rst ? 1'b0 : ifIdWrite;
    assign op_IF_ID_Flush = ip_rst ? 1'b1 : ifIdFlush;
    assign op_ID_EX_Flush = ip_rst ? 1'b1 : idExFlush;
    assign op_Pipe_Freeze = ip_rst ? 1'b0 : pipeFreeze;
    assign op_Mem_Timeout = timeoutFlag;
    assign op_State       = state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt, flushCnt;

    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            stallCnt <= 32'd0;
            flushCnt <= 32'd0;
        end else begin
            if (!pcWrite) stallCnt <= stallCnt + 32'd1;
            if (branchAccept) flushCnt <= flushCnt + 32'd1;
        end
    end

    assign op_Stall_Cnt = stallCnt;
    assign op_Flush_Cnt = flushCnt;
`endif

endmodule
